// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with locked bursts in front of a single-port data memory.
// Read data and error pulses are registered one cycle after the grant.
module dmem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int DMEM_DEPTH = 1024,
   parameter int MAX_BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(DMEM_DEPTH);

   logic             rr_last;
   logic             lock_owner_valid;
   logic             lock_owner;
   logic [CNT_W-1:0] burst_cnt;

   logic in_range0;
   logic in_range1;
   logic lock_active;
   logic forced;
   logic gnt_lock;

   assign in_range0 = ({1'b0, addr0} < DEPTH);
   assign in_range1 = ({1'b0, addr1} < DEPTH);

   // The lock only counts while its owner keeps both req and lock asserted.
   assign lock_active = lock_owner_valid &&
                        (lock_owner ? (req1 && lock1) : (req0 && lock0));

   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      forced = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
            if (lock_active) begin
               if (burst_cnt < MAX_CNT) begin
                  gnt0 = !lock_owner;
                  gnt1 = lock_owner;
               end else begin
                  gnt0   = lock_owner;
                  gnt1   = !lock_owner;
                  forced = 1'b1;
               end
            end else begin
               gnt0 = rr_last;
               gnt1 = !rr_last;
            end
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign mem_a    = gnt1 ? addr1 : addr0;
   assign mem_wd   = gnt1 ? wdata1 : wdata0;
   assign mem_we   = (gnt0 && we0 && in_range0) || (gnt1 && we1 && in_range1);
   assign gnt_lock = gnt1 ? lock1 : lock0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last          <= 1'b1;
         lock_owner_valid <= 1'b0;
         lock_owner       <= 1'b0;
         burst_cnt        <= '0;
         rvalid0          <= 1'b0;
         rvalid1          <= 1'b0;
         err0             <= 1'b0;
         err1             <= 1'b0;
         rdata0           <= '0;
         rdata1           <= '0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         if (gnt0) begin
            if (!in_range0) begin
               err0   <= 1'b1;
               rdata0 <= '0;
            end else if (!we0) begin
               rvalid0 <= 1'b1;
               rdata0  <= mem_rd;
            end
         end
         if (gnt1) begin
            if (!in_range1) begin
               err1   <= 1'b1;
               rdata1 <= '0;
            end else if (!we1) begin
               rvalid1 <= 1'b1;
               rdata1  <= mem_rd;
            end
         end

         // A grant below overrides this release when it opens a new burst.
         if (lock_owner_valid && !lock_active) begin
            lock_owner_valid <= 1'b0;
            burst_cnt        <= '0;
         end
         if (gnt0 || gnt1) begin
            rr_last <= gnt1;
            if (forced || !gnt_lock) begin
               lock_owner_valid <= 1'b0;
               burst_cnt        <= '0;
            end else if (lock_owner_valid && (lock_owner == gnt1)) begin
               if (burst_cnt < MAX_CNT) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end else begin
               lock_owner       <= gnt1;
               lock_owner_valid <= 1'b1;
               burst_cnt        <= CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a behavioural single-port data memory.
module tb_dmem_arbiter;

   localparam logic [31:0] DC = 32'hxxxxxxxx;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
   logic [31:0] rdata0, rdata1, mem_wd, mem_rd;
   logic [15:0] mem_a;

   logic [31:0] mem [0:1023];

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        rst;
      logic        req0, we0, lock0;
      logic [15:0] addr0;
      logic [31:0] wdata0;
      logic        req1, we1, lock1;
      logic [15:0] addr1;
      logic [31:0] wdata1;
      logic        egnt0, egnt1, emwe;
      logic        erv0, erv1, eerr0, eerr1;
      logic [31:0] erd0, erd1;
   } vec_t;

   vec_t vecs[$];

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = (mem_a < 16'd1024) ? mem[mem_a[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && (mem_a < 16'd1024)) mem[mem_a[9:0]] <= mem_wd;
   end

   task automatic addVec(input logic r,
                         input logic q0, input logic w0, input logic l0,
                         input logic [15:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic l1,
                         input logic [15:0] a1, input logic [31:0] d1,
                         input logic g0, input logic g1, input logic mwe,
                         input logic rv0, input logic rv1, input logic e0, input logic e1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t v;
      v.rst = r;
      v.req0 = q0; v.we0 = w0; v.lock0 = l0; v.addr0 = a0; v.wdata0 = d0;
      v.req1 = q1; v.we1 = w1; v.lock1 = l1; v.addr1 = a1; v.wdata1 = d1;
      v.egnt0 = g0; v.egnt1 = g1; v.emwe = mwe;
      v.erv0 = rv0; v.erv1 = rv1; v.eerr0 = e0; v.eerr1 = e1;
      v.erd0 = rd0; v.erd1 = rd1;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst    = v.rst;
      req0   = v.req0;  we0 = v.we0;  lock0 = v.lock0;  addr0 = v.addr0;  wdata0 = v.wdata0;
      req1   = v.req1;  we1 = v.we1;  lock1 = v.lock1;  addr1 = v.addr1;  wdata1 = v.wdata1;
   endtask

   // An all-x expectation marks a value the design is free to choose.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      if ($isunknown(exp)) return;
      checkCount++;
      if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      else passCount++;
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, 32'(act), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'h00000011; mem[1] = 32'h00000022; mem[2] = 32'h01020106;
      mem[3] = 32'h00000033; mem[4] = 32'h00000044; mem[5] = 32'h00000055;
      mem[6] = 32'h00000066;

      //     rst q0 w0 l0 addr0    wdata0         q1 w1 l1 addr1    wdata1         g0 g1 we rv0 rv1 e0 e1 rd0           rd1
      addVec(1,  1, 1, 0, 16'h0,   32'h0,         1, 0, 0, 16'h0,   32'h0,         0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      addVec(0,  1, 0, 0, 16'h2,   32'h0,         0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         1, 1, 0, 16'h6,   32'hDEADBEEF,  0, 1, 1, 1, 0, 0, 0, 32'h01020106, 32'h0);
      addVec(0,  1, 0, 0, 16'h6,   32'h0,         0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h01020106, DC);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, DC);
      addVec(1,  1, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'h1,   32'h0,         0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, DC);
      addVec(0,  1, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'h1,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      addVec(0,  1, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'h1,   32'h0,         0, 1, 0, 1, 0, 0, 0, 32'h11,       32'h0);
      addVec(0,  1, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'h1,   32'h0,         1, 0, 0, 0, 1, 0, 0, 32'h11,       32'h22);
      addVec(0,  1, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'h1,   32'h0,         0, 1, 0, 1, 0, 0, 0, 32'h11,       32'h22);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 0, 1, 0, 0, 32'h11,       32'h22);
      addVec(0,  1, 0, 0, 16'h3,   32'h0,         0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h11,       32'h22);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 1, 0, 0, 0, 32'h33,       32'h22);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 0, 1, 0, 0, 32'h33,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 0, 1, 0, 0, 32'h33,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 0, 1, 0, 0, 32'h33,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         1, 0, 0, 0, 1, 0, 0, 32'h33,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 1, 0, 0, 0, 32'h44,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 1, 0, 0, 1, 0, 0, 32'h44,       32'h55);
      addVec(1,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         0, 0, 0, 0, 1, 0, 0, 32'h44,       32'h55);
      addVec(0,  1, 0, 0, 16'h4,   32'h0,         1, 0, 1, 16'h5,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 1, 0, 0, 0, 32'h44,       32'h0);
      addVec(0,  1, 0, 0, 16'h400, 32'h0,         0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 0, 0, 32'h44,       32'h0);
      addVec(0,  1, 1, 0, 16'h400, 32'hCAFEF00D,  0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 16'hFFFF, 32'h0,        0, 1, 0, 0, 0, 1, 0, 32'h0,        32'h0);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0);
      addVec(0,  1, 1, 0, 16'h3,   32'h12345678,  0, 0, 0, 16'h0,   32'h0,         1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0);
      addVec(0,  1, 0, 0, 16'h3,   32'h0,         0, 0, 0, 16'h0,   32'h0,         1, 0, 0, 0, 0, 0, 0, DC,           32'h0);
      addVec(0,  0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 16'h0,   32'h0,         0, 0, 0, 1, 0, 0, 0, 32'h12345678, 32'h0);

      rst = 1'b1;
      req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkBit($sformatf("v%0d gnt0", i), gnt0, vecs[i].egnt0);
         checkBit($sformatf("v%0d gnt1", i), gnt1, vecs[i].egnt1);
         checkBit($sformatf("v%0d mem_we", i), mem_we, vecs[i].emwe);
         checkBit($sformatf("v%0d rvalid0", i), rvalid0, vecs[i].erv0);
         checkBit($sformatf("v%0d rvalid1", i), rvalid1, vecs[i].erv1);
         checkBit($sformatf("v%0d err0", i), err0, vecs[i].eerr0);
         checkBit($sformatf("v%0d err1", i), err1, vecs[i].eerr1);
         checkOutput($sformatf("v%0d rdata0", i), rdata0, vecs[i].erd0);
         checkOutput($sformatf("v%0d rdata1", i), rdata1, vecs[i].erd1);
      end

      // Port 0 locks alone, keeps its burst when port 1 joins, then releases to round-robin.
      @(negedge clk);
      rst = 0; req0 = 1; lock0 = 1; we0 = 0; addr0 = 16'h0; req1 = 0; lock1 = 0; we1 = 0; addr1 = 16'h1;
      #1 checkBit("seq lock0 first gnt0", gnt0, 1'b1);
      @(negedge clk);
      #1 checkBit("seq lock0 second gnt0", gnt0, 1'b1);
      @(negedge clk);
      req1 = 1;
      #1 checkBit("seq lock0 held gnt0", gnt0, 1'b1);
      checkBit("seq lock0 held gnt1", gnt1, 1'b0);
      @(negedge clk);
      lock0 = 0;
      #1 checkBit("seq release gnt1", gnt1, 1'b1);
      checkBit("seq release gnt0", gnt0, 1'b0);
      @(negedge clk);
      req0 = 0; req1 = 0;
      @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
